// File: rtl/picomem_pkg.sv
// Shared definitions for the picomem SRAM controller: bus widths and FSM state encoding.
package picomem_pkg;

  localparam int PICOMEM_DATA_W = 32;
  localparam int PICOMEM_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } picomem_state_e;

endpackage

// File: rtl/picomem_sram_bank.sv
// One 8-bit byte lane of the SRAM array; read-first, registered output, block-RAM inferable.
module picomem_sram_bank #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);

  logic [7:0] mem [2**ADDR_W];

  // dout captures the old word even when the same cycle writes it
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/picomem_sram_ctrl.sv
// PicoRV32 native-bus SRAM controller: range check, optional wait states, one-cycle ready pulse.
module picomem_sram_ctrl
  import picomem_pkg::*;
#(
  parameter int          ADDR_W         = 11,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WAIT_STATES    = 0,
  parameter int          ERR_ZERO_RDATA = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_s_valid,
  input  logic [31:0]               mem_s_addr,
  input  logic [PICOMEM_DATA_W-1:0] mem_s_wdata,
  input  logic [PICOMEM_STRB_W-1:0] mem_s_wstrb,
  output logic                      mem_s_ready,
  output logic [PICOMEM_DATA_W-1:0] mem_s_rdata,
  output logic                      mem_s_err,
  output logic                      busy
);

  localparam logic [32:0] CAPACITY = 33'(4) << ADDR_W;
  localparam logic [2:0]  WS_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  picomem_state_e              state;
  logic [ADDR_W-1:0]           addr_q;
  logic [PICOMEM_DATA_W-1:0]   wdata_q;
  logic [PICOMEM_STRB_W-1:0]   wstrb_q;
  logic                        in_range_q;
  logic [2:0]                  wcnt;
  logic [PICOMEM_DATA_W-1:0]   last_rdata;

  logic [31:0]                 offset;
  logic                        in_range_d;
  logic                        bank_ce;
  logic [PICOMEM_DATA_W-1:0]   bank_dout;
  logic [PICOMEM_DATA_W-1:0]   resp_rdata;

  // Offset is unsigned, so addresses below BASE wrap high and fail the check
  assign offset     = mem_s_addr - BASE_ADDR;
  assign in_range_d = ({1'b0, offset} < CAPACITY);

  // Reset in the ACCESS cycle must keep the array untouched
  assign bank_ce = (state == ST_ACCESS) && in_range_q && !reset;

  for (genvar g = 0; g < PICOMEM_STRB_W; g++) begin : g_lane
    picomem_sram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk  (clk),
      .ce   (bank_ce),
      .we   (wstrb_q[g]),
      .addr (addr_q),
      .din  (wdata_q[8*g +: 8]),
      .dout (bank_dout[8*g +: 8])
    );
  end

  always_comb begin
    resp_rdata = last_rdata;
    if (in_range_q)
      resp_rdata = bank_dout;
    else if (ERR_ZERO_RDATA != 0)
      resp_rdata = '0;
  end

  // Bank output is already registered; the mux selects on registered state only
  assign mem_s_rdata = (state == ST_RESP) ? resp_rdata : last_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      in_range_q  <= 1'b0;
      wcnt        <= '0;
      last_rdata  <= '0;
      mem_s_ready <= 1'b0;
      mem_s_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_s_ready <= 1'b0;
      mem_s_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_s_valid) begin
            addr_q     <= offset[ADDR_W+1:2];
            wdata_q    <= mem_s_wdata;
            wstrb_q    <= mem_s_wstrb;
            in_range_q <= in_range_d;
            state      <= ST_ACCESS;
            busy       <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (WAIT_STATES > 0) begin
            wcnt  <= WS_LOAD;
            state <= ST_WAIT;
          end else begin
            state       <= ST_RESP;
            mem_s_ready <= 1'b1;
            mem_s_err   <= ~in_range_q;
          end
        end
        ST_WAIT: begin
          if (wcnt == 3'd0) begin
            state       <= ST_RESP;
            mem_s_ready <= 1'b1;
            mem_s_err   <= ~in_range_q;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        ST_RESP: begin
          last_rdata <= resp_rdata;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picomem_sram_ctrl.sv
// Directed bench for picomem_sram_ctrl: three instances (default, 3 wait states, non-zero base).
module tb_picomem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        v   [3];
  logic [31:0] a   [3];
  logic [31:0] wd  [3];
  logic [3:0]  st  [3];
  logic        rdy [3];
  logic [31:0] rd  [3];
  logic        er  [3];
  logic        bz  [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  picomem_sram_ctrl u_ws0 (
    .clk(clk), .reset(rst[0]), .mem_s_valid(v[0]), .mem_s_addr(a[0]),
    .mem_s_wdata(wd[0]), .mem_s_wstrb(st[0]), .mem_s_ready(rdy[0]),
    .mem_s_rdata(rd[0]), .mem_s_err(er[0]), .busy(bz[0])
  );

  picomem_sram_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[1]), .mem_s_valid(v[1]), .mem_s_addr(a[1]),
    .mem_s_wdata(wd[1]), .mem_s_wstrb(st[1]), .mem_s_ready(rdy[1]),
    .mem_s_rdata(rd[1]), .mem_s_err(er[1]), .busy(bz[1])
  );

  picomem_sram_ctrl #(.BASE_ADDR(32'h1000_0000)) u_base (
    .clk(clk), .reset(rst[2]), .mem_s_valid(v[2]), .mem_s_addr(a[2]),
    .mem_s_wdata(wd[2]), .mem_s_wstrb(st[2]), .mem_s_ready(rdy[2]),
    .mem_s_rdata(rd[2]), .mem_s_err(er[2]), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Drive one request at a negedge, drop valid after the accept edge, wait for ready.
  task automatic access(input int i, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int lat_exp, input string tag,
                        output logic [31:0] rdata, output logic err);
    int cyc;
    cyc   = 0;
    rdata = 'x;
    err   = 1'bx;
    v[i] = 1'b1; a[i] = addr; wd[i] = data; st[i] = strb;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        v[i] = 1'b0; a[i] = 32'h0000_0FF0; wd[i] = 32'h5A5A_5A5A;
      end
      if (rdy[i]) break;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat_exp));
    rdata = rd[i];
    err   = er[i];
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, rdy[i]}, 32'h0);
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; v[i] = 1'b0; a[i] = '0; wd[i] = '0; st[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    check("rst_ready", {31'b0, rdy[0]}, 32'h0);
    check("rst_err",   {31'b0, er[0]},  32'h0);
    check("rst_rdata", rd[0],           32'h0);
    check("rst_busy",  {31'b0, bz[0]},  32'h0);

    // Full write then readback
    access(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, "wr10", r, e);
    check("wr10_err", {31'b0, e}, 32'h0);
    access(0, 32'h0000_0010, 32'h0, 4'h0, 2, "rd10", r, e);
    check("rd10_data", r, 32'hDEAD_BEEF);
    check("rd10_err", {31'b0, e}, 32'h0);
    check("rd10_hold", rd[0], 32'hDEAD_BEEF);

    // Partial write: response returns the pre-write word
    access(0, 32'h0000_0030, 32'h1122_3344, 4'hF, 2, "wr30", r, e);
    access(0, 32'h0000_0030, 32'h0000_AA00, 4'b0010, 2, "pw30", r, e);
    check("pw30_old", r, 32'h1122_3344);
    access(0, 32'h0000_0030, 32'h0, 4'h0, 2, "rd30", r, e);
    check("rd30_data", r, 32'h1122_AA44);
    // Address bits [1:0] ignored
    access(0, 32'h0000_0033, 32'h0, 4'h0, 2, "rd33", r, e);
    check("rd33_data", r, 32'h1122_AA44);

    // Out-of-range aliasing index 0 must not corrupt it
    access(0, 32'h0000_0000, 32'h0102_0304, 4'hF, 2, "wr0", r, e);
    access(0, 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 2, "oorw", r, e);
    check("oorw_err", {31'b0, e}, 32'h1);
    access(0, 32'h0000_2000, 32'h0, 4'h0, 2, "oorr", r, e);
    check("oorr_err", {31'b0, e}, 32'h1);
    check("oorr_data", r, 32'h0);
    access(0, 32'h0000_0000, 32'h0, 4'h0, 2, "rd0", r, e);
    check("rd0_data", r, 32'h0102_0304);
    check("rd0_err", {31'b0, e}, 32'h0);

    // Reset coinciding with ACCESS suppresses the write
    access(0, 32'h0000_0020, 32'h0000_0055, 4'hF, 2, "wr20", r, e);
    v[0] = 1'b1; a[0] = 32'h0000_0020; wd[0] = 32'h9999_9999; st[0] = 4'hF;
    @(negedge clk);
    v[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rstacc_busy", {31'b0, bz[0]}, 32'h0);
    check("rstacc_rdy", {31'b0, rdy[0]}, 32'h0);
    access(0, 32'h0000_0020, 32'h0, 4'h0, 2, "rd20", r, e);
    check("rd20_data", r, 32'h0000_0055);

    // Back-to-back with valid held; mid-access address change ignored
    access(0, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 2, "wr24", r, e);
    v[0] = 1'b1; a[0] = 32'h0000_0010; st[0] = 4'h0;
    @(negedge clk);
    a[0] = 32'h0000_0024;
    @(negedge clk);
    check("b2b1_rdy", {31'b0, rdy[0]}, 32'h1);
    check("b2b1_data", rd[0], 32'hDEAD_BEEF);
    @(negedge clk);
    check("b2b_idle_rdy", {31'b0, rdy[0]}, 32'h0);
    check("b2b_idle_busy", {31'b0, bz[0]}, 32'h0);
    @(negedge clk);
    v[0] = 1'b0;
    check("b2b2_busy", {31'b0, bz[0]}, 32'h1);
    @(negedge clk);
    check("b2b2_rdy", {31'b0, rdy[0]}, 32'h1);
    check("b2b2_data", rd[0], 32'hCAFE_F00D);

    // Three wait states: busy window and latency
    access(1, 32'h0000_0040, 32'h7777_8888, 4'hF, 5, "w3wr", r, e);
    v[1] = 1'b1; a[1] = 32'h0000_0040; st[1] = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) v[1] = 1'b0;
      check($sformatf("w3_busy_c%0d", c), {31'b0, bz[1]}, (c <= 5) ? 32'h1 : 32'h0);
      check($sformatf("w3_rdy_c%0d", c), {31'b0, rdy[1]}, (c == 5) ? 32'h1 : 32'h0);
      if (c == 5) check("w3_data", rd[1], 32'h7777_8888);
    end

    // Reset while in WAIT during a write
    v[1] = 1'b1; a[1] = 32'h0000_0044; wd[1] = 32'h1234_5678; st[1] = 4'hF;
    @(negedge clk);
    v[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("w3rst_rdy%0d", c), {31'b0, rdy[1]}, 32'h0);
      check($sformatf("w3rst_busy%0d", c), {31'b0, bz[1]}, 32'h0);
      @(negedge clk);
    end
    access(1, 32'h0000_0040, 32'h0, 4'h0, 5, "w3rd", r, e);
    check("w3rd_data", r, 32'h7777_8888);

    // Non-zero base: below-base and above-range both error
    access(2, 32'h1000_0000, 32'h0A0B_0C0D, 4'hF, 2, "bwr", r, e);
    check("bwr_err", {31'b0, e}, 32'h0);
    access(2, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2, "blow_w", r, e);
    check("blow_w_err", {31'b0, e}, 32'h1);
    access(2, 32'h0FFF_FFFC, 32'h0, 4'h0, 2, "blow_r", r, e);
    check("blow_r_err", {31'b0, e}, 32'h1);
    check("blow_r_data", r, 32'h0);
    access(2, 32'h1000_2000, 32'hFFFF_FFFF, 4'hF, 2, "bhi_w", r, e);
    check("bhi_w_err", {31'b0, e}, 32'h1);
    access(2, 32'h1000_0000, 32'h0, 4'h0, 2, "brd", r, e);
    check("brd_data", r, 32'h0A0B_0C0D);
    check("brd_err", {31'b0, e}, 32'h0);
    access(2, 32'h1000_1FFC, 32'h0, 4'h0, 2, "btop", r, e);
    check("btop_err", {31'b0, e}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
